// File: rtl/panel_pkg.sv
// Shared types and switch-word layout helpers for the front-panel load/store sequencer.
package panel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_ST = 1'b1
    } op_e;

    // Switch word, LSB first: off, base, rt, op, one unused bit.
    localparam int SW_OFF_LSB = 0;

    function automatic int sw_base_lsb(input int off_w);
        return off_w;
    endfunction

    function automatic int sw_rt_lsb(input int reg_aw, input int off_w);
        return off_w + reg_aw;
    endfunction

    function automatic int sw_op_bit(input int reg_aw, input int off_w);
        return off_w + 2 * reg_aw;
    endfunction

    function automatic int sw_width(input int reg_aw, input int off_w);
        return 2 + 2 * reg_aw + off_w;
    endfunction

    function automatic int page_width(input int data_w, input int led_w);
        int n_pages;
        n_pages = data_w / led_w;
        return (n_pages <= 1) ? 1 : $clog2(n_pages);
    endfunction

endpackage

// File: rtl/panel_ldst_sequencer_debounce.sv
// Two-flop synchroniser, symmetric debounce counter and one-cycle pulse on each accepted press.
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            pulse   <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                pulse   <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_ldst_sequencer.sv
// Front-panel LD/ST sequencer: decode switches, read regs, add address, run a req/ack memory
// transaction, write back loads, and show a paged LED view of the selected register.
module panel_ldst_sequencer
    import panel_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 4,
    parameter int MEM_AW       = 8,
    parameter int OFF_W        = 6,
    parameter int LED_W        = 16,
    parameter int DEBOUNCE_CYC = 2,
    parameter int TIMEOUT_CYC  = 16,
    localparam int SW_W        = sw_width(REG_AW, OFF_W),
    localparam int PAGE_W      = page_width(DATA_W, LED_W)
) (
    input  logic              clk,
    input  logic              reset_btn,
    input  logic              execute_btn,
    input  logic [SW_W-1:0]   sw,
    input  logic [PAGE_W-1:0] disp_page,
    output logic [REG_AW-1:0] rf_raddr_a,
    input  logic [DATA_W-1:0] rf_rdata_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              err
);
    localparam int N_PAGES  = DATA_W / LED_W;
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int OP_BIT   = sw_op_bit(REG_AW, OFF_W);
    localparam int RT_LSB   = sw_rt_lsb(REG_AW, OFF_W);
    localparam int BASE_LSB = sw_base_lsb(OFF_W);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [REG_AW-1:0]   rt_q, base_q;
    logic [OFF_W-1:0]    off_q;
    logic [DATA_W-1:0]   ld_data_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [LED_W-1:0]    led_d;
    logic                exec_pulse;
    logic                tmo_hit;

    logic [REG_AW-1:0]   sw_rt, sw_base;
    logic [OFF_W-1:0]    sw_off;
    logic                sw_op;
    logic                unused_bits;

    assign sw_op       = sw[OP_BIT];
    assign sw_rt       = sw[RT_LSB +: REG_AW];
    assign sw_base     = sw[BASE_LSB +: REG_AW];
    assign sw_off      = sw[SW_OFF_LSB +: OFF_W];
    assign unused_bits = ^{sw[SW_W-1], rf_rdata_a[DATA_W-1:MEM_AW]};

    btn_debounce_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk   (clk),
        .reset (reset_btn),
        .btn   (execute_btn),
        .pulse (exec_pulse)
    );

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (exec_pulse) state_d = ADDR;
            ADDR:    state_d = MEM;
            MEM: begin
                // An ack in the expiry cycle still completes the transaction.
                if (mem_ack)      state_d = (op_q == OP_ST) ? IDLE : WB;
                else if (tmo_hit) state_d = IDLE;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign mem_req    = (state_q == MEM);
    assign rf_we      = (state_q == WB);
    assign rf_waddr   = rt_q;
    assign rf_wdata   = ld_data_q;
    assign rf_raddr_a = (state_q == IDLE) ? sw_base : base_q;
    assign rf_raddr_b = (state_q == IDLE) ? sw_rt   : rt_q;

    // Out-of-range pages fall through to zero.
    always_comb begin
        led_d = '0;
        for (int p = 0; p < N_PAGES; p++) begin
            if (disp_page == PAGE_W'(p)) led_d = rf_rdata_b[p*LED_W +: LED_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_btn) begin
            state_q   <= IDLE;
            op_q      <= OP_LD;
            rt_q      <= '0;
            base_q    <= '0;
            off_q     <= '0;
            ld_data_q <= '0;
            tmo_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            led       <= '0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            led     <= led_d;
            case (state_q)
                IDLE: begin
                    if (exec_pulse) begin
                        op_q   <= op_e'(sw_op);
                        rt_q   <= sw_rt;
                        base_q <= sw_base;
                        off_q  <= sw_off;
                        err    <= 1'b0;
                    end
                end
                ADDR: begin
                    mem_addr  <= rf_rdata_a[MEM_AW-1:0] + MEM_AW'(off_q);
                    mem_wdata <= rf_rdata_b;
                    mem_we    <= op_q;
                    tmo_q     <= '0;
                end
                MEM: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (mem_ack) begin
                        if (op_q == OP_LD) ld_data_q <= mem_rdata;
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/panel_ldst_sequencer.md
Name: panel_ldst_sequencer

Overview:
Parametrised front-panel load/store sequencer for the Mini-MIPS board. It debounces the execute button, then decodes a switch-encoded LD/ST word. It sequences the register-file read, the address add, a req/ack memory transaction and the register writeback, and drives a paged LED view of any register. Generalises the fixed 32-bit / 16-LED panel path with configurable widths, memory-latency tolerance, a timeout error and debounce.

Parameters:
DATA_W, 32, register/memory word width (multiple of LED_W)
REG_AW, 4, register address width
MEM_AW, 8, memory word-address width
OFF_W, 6, unsigned offset width
LED_W, 16, LED bank width
DEBOUNCE_CYC, 2, consecutive synchronised high samples required to accept a press
TIMEOUT_CYC, 16, max MEM-state cycles waiting for mem_ack
Derived: SW_W = 2+2*REG_AW+OFF_W (16); PAGE_W = max(1, clog2(DATA_W/LED_W))

Ports:
clk  in  1  system clock
reset_btn  in  1  synchronous, active-high reset
execute_btn  in  1  raw asynchronous button
sw  in  SW_W  fields: [SW_W-1] unused; [SW_W-2] op (0=LD, 1=ST); next REG_AW = rt; next REG_AW = base; [OFF_W-1:0] = off
disp_page  in  PAGE_W  LED slice select (0 = LSBs)
rf_raddr_a  out  REG_AW  base register read address
rf_rdata_a  in  DATA_W  combinational read data A
rf_raddr_b  out  REG_AW  rt read address (store data / display)
rf_rdata_b  in  DATA_W  combinational read data B
rf_we  out  1  writeback strobe
rf_waddr  out  REG_AW  writeback address
rf_wdata  out  DATA_W  writeback data
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = store
mem_addr  out  MEM_AW  word address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  one-cycle completion
mem_rdata  in  DATA_W  load data, valid with mem_ack
led  out  LED_W  registered display slice
busy  out  1  state != IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0. State = IDLE, debounce counter and timeout counter = 0.
- Debounce: execute_btn passes through a 2-flop synchroniser. The level is accepted after DEBOUNCE_CYC consecutive high samples. exec_pulse is high for exactly 1 cycle on each accepted rising edge; re-arming requires DEBOUNCE_CYC low samples. Any low sample during the count restarts it.
- IDLE: rf_raddr_a = sw.base and rf_raddr_b = sw.rt, both live from the switches. On exec_pulse: latch op/rt/base/off, clear err, go to ADDR.
- exec_pulse arriving while busy is dropped; there is no queue.
- ADDR (1 cycle): mem_addr <= rf_rdata_a[MEM_AW-1:0] + zero-extended off, modulo 2^MEM_AW (wraps silently). mem_wdata <= rf_rdata_b, mem_we <= op. Go to MEM.
- MEM: mem_req = 1; mem_addr, mem_we and mem_wdata stay stable. The timeout counter increments each cycle.
  - mem_ack && ST: go to IDLE.
  - mem_ack && LD: capture mem_rdata, go to WB.
  - Counter reaches TIMEOUT_CYC without ack: err <= 1, go to IDLE, no writeback. Ack in the expiry cycle wins.
- mem_req drops in the cycle after ack or timeout. mem_ack outside MEM is ignored.
- WB (1 cycle): rf_we = 1, rf_waddr = latched rt, rf_wdata = captured data. Go to IDLE.
- Latency with ack in the first MEM cycle, exec_pulse at cycle T:
  - ST: mem_req at T+2, IDLE at T+3.
  - LD: rf_we at T+3, led reflects the new value at T+5 (display rt unchanged).
- Display: led <= rf_rdata_b[disp_page*LED_W +: LED_W]. led = 0 if disp_page >= DATA_W/LED_W. One-cycle latency, updated every cycle including when busy; while busy it shows the latched rt.
- Reset mid-operation: state returns to IDLE; mem_req and rf_we are 0 from the next edge; no write is issued; err is cleared.
- Writes to R0 are not special-cased; the register file owns that policy.

Decomposition:
- Package panel_pkg:
  - state enum {IDLE, ADDR, MEM, WB}
  - sw field offset constants
  - SW_W/PAGE_W helper functions
  - op encodings LD=0, ST=1
- Sub-module btn_debounce_pulse (synchroniser, debounce counter, one-shot), parametrised by DEBOUNCE_CYC.
- FSM, datapath and LED mux stay in panel_ldst_sequencer.

Test Plan:
Bench models: register file with Rn = n; memory with Mem[n] = n and a configurable ack delay (0..3 cycles).
1. sw=0x1803 (LD R6,3(R0)), 3-cycle press -> mem_addr=3, mem_we=0; rf_we with waddr=6, wdata=3; led page0=0x0003, page1=0x0000.
2. sw=0x4408 (ST R1,8(R0)) -> mem_we=1, mem_addr=8, mem_wdata=1, no rf_we. Then sw=0x2008 (LD R8,8(R0)) -> R8=1, led=0x0001. Repeat with ack delay 3; mem_req must stay stable for 4 cycles.
3. Preload R3=0xF0; LD R2,63(R3) -> mem_addr=0x2F (wrap). R3=0xDEADBEEF shown with disp_page=1 -> led=0xDEAD; disp_page=0 -> 0xBEEF.
4. Memory never acks -> mem_req high exactly 16 cycles, then err=1, busy=0, no rf_we. The next accepted execute clears err.
5. 1-cycle execute glitch -> no exec_pulse/mem_req. A second press during MEM -> exactly one transaction.
6. reset_btn asserted 1 cycle while in MEM -> next cycle mem_req=0, busy=0, err=0, led=0, no rf_we.
